// File: rtl/gpio_bank.sv
// Bus-mapped GPIO bank: direction/output/input registers, edge-detect STATUS (W1C) and a registered level irq.
// Pin->IN after 2 edges, ->STATUS/irq after 3; bus accesses are single-cycle with no stall. Debounce via GPIO_DEBOUNCE_EN.
module gpio_bank #(
    parameter int          PIN_COUNT       = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h4030,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    inout  wire  [31:0]          data_bus_data,
    input  logic [31:0]          data_bus_addr,
    input  logic [1:0]           data_bus_mode,
    inout  wire  [PIN_COUNT-1:0] gpio_pins,
    output logic                 irq
);
    logic [PIN_COUNT-1:0] dir_q, out_q, rise_en_q, fall_en_q, status_q;
    logic [PIN_COUNT-1:0] sync0_q, sync1_q, prev_q, in_val;
    logic [PIN_COUNT-1:0] wdat, rdata, evt, clr, status_nxt;
    logic [31:0]          off;
    logic [3:0]           idx;
    logic                 hit, rd_en, wr_en;

    // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
    assign off   = data_bus_addr - BASE_ADDR;
    assign hit   = off < 32'd9;
    assign idx   = off[3:0];
    assign rd_en = hit && (data_bus_mode == 2'b01);
    assign wr_en = hit && (data_bus_mode == 2'b10);
    assign wdat  = data_bus_data[PIN_COUNT-1:0];

    always_comb begin
        rdata = '0;
        case (idx)
            4'd0:    rdata = dir_q;
            4'd1:    rdata = out_q;
            4'd2:    rdata = in_val;
            4'd6:    rdata = rise_en_q;
            4'd7:    rdata = fall_en_q;
            4'd8:    rdata = status_q;
            default: rdata = '0;
        endcase
    end

    assign data_bus_data = rd_en ? 32'(rdata) : 32'bz;

    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pad
        assign gpio_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // A new edge event wins over a same-cycle W1C clear of that bit.
    assign evt        = (in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q);
    assign clr        = (wr_en && idx == 4'd8) ? wdat : '0;
    assign status_nxt = (status_q & ~clr) | evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync0_q   <= '0;
            sync1_q   <= '0;
            prev_q    <= '0;
            irq       <= 1'b0;
        end else begin
            sync0_q  <= gpio_pins;
            sync1_q  <= sync0_q;
            prev_q   <= in_val;
            status_q <= status_nxt;
            irq      <= |status_nxt;
            if (wr_en) begin
                case (idx)
                    4'd0:    dir_q     <= wdat;
                    4'd1:    out_q     <= wdat;
                    4'd3:    out_q     <= out_q | wdat;
                    4'd4:    out_q     <= out_q & ~wdat;
                    4'd5:    out_q     <= out_q ^ wdat;
                    4'd6:    rise_en_q <= wdat;
                    4'd7:    fall_en_q <= wdat;
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]        cnt_q [PIN_COUNT];
    logic [PIN_COUNT-1:0] in_q;

    assign in_val = in_q;

    // IN follows sync1 only after DEBOUNCE_CYCLES consecutive differing edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q <= '0;
            for (int i = 0; i < PIN_COUNT; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < PIN_COUNT; i++) begin
                if (sync1_q[i] != in_q[i]) begin
                    if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        in_q[i]  <= sync1_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, data_bus_data};
`else
    assign in_val = sync1_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, data_bus_data, 8'(DEBOUNCE_CYCLES)};
`endif
endmodule
